// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//
// Purpose:
//   Shared definitions for the chunked serial adder: the controller state
//   encoding and a helper that sizes the chunk index register.
//
// Contents:
//   state_t   - IDLE / RUN / DONE, 2-bit encoding
//   idx_width - bits needed to count NCHUNK chunks (never less than 1)
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk adder still needs a 1-bit index so the register
    // declaration stays legal.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
//
// Purpose:
//   Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
//   The serial adder instantiates one of these and feeds it a different
//   operand slice every cycle.
//
// Ports:
//   x, y  in  [CHUNK-1:0]  operand slices
//   cin   in  1            carry into bit 0
//   s     out [CHUNK-1:0]  slice sum
//   cout  out 1            carry out of the top bit
//   cmsb  out 1            carry into the top bit (for signed overflow)
// -----------------------------------------------------------------------------
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit; the carry ripples upward through c.
    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        assign s[i]     = x[i] ^ y[i] ^ c[i];
        assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK - 1];

endmodule

// File: rtl/chunked_serial_adder.sv
// -----------------------------------------------------------------------------
// chunked_serial_adder
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, with
//   the inter-chunk carry held in a register. A start/busy/done handshake
//   frames each addition; the result is registered and held until the next
//   completion.
//
// Parameters:
//   WIDTH  operand/sum width, must be a multiple of CHUNK
//   CHUNK  bits added per cycle, 1 <= CHUNK <= WIDTH
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   request, honoured only in IDLE or DONE
//   a, b   in   [WIDTH-1:0] operands, captured on an accepted start
//   ci     in   carry-in, captured on an accepted start
//   busy   out  high while chunks are being added
//   done   out  one-cycle completion pulse
//   sum    out  [WIDTH-1:0] registered result
//   co     out  registered carry-out
//   ovf    out  registered signed overflow (only with SIGNED_OVF_EN)
//
// Build option:
//   SIGNED_OVF_EN - when defined, adds the ovf output and its register.
// -----------------------------------------------------------------------------
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Guarded divisor so a bad CHUNK reaches the check below instead of
    // tripping a divide-by-zero first.
    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
    localparam int IDX_W      = idx_width(NCHUNK);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_params
        $error("chunked_serial_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic               carry;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   chunk_s;
    logic               chunk_cout;
    logic               chunk_cmsb;
    logic               last_chunk;
    logic               accept;

    assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

    // Operand slice mux: the index picks which chunk of the latched
    // operands goes through the shared adder this cycle.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                a_chunk = a_r[k*CHUNK +: CHUNK];
                b_chunk = b_r[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x    (a_chunk),
        .y    (b_chunk),
        .cin  (carry),
        .s    (chunk_s),
        .cout (chunk_cout),
        .cmsb (chunk_cmsb)
    );

    // Merge this cycle's slice sum into the partial result. On the last
    // chunk this is the complete sum, so it can be published directly.
    always_comb begin
        acc_next = acc;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                acc_next[k*CHUNK +: CHUNK] = chunk_s;
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. DONE accepts a new start just like
    // IDLE, which lets back-to-back additions skip the idle cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: capture operands on accept, then walk one chunk per cycle.
    // sum/co only move on the final chunk so they stay stable during RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            sum   <= '0;
            co    <= 1'b0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= b;
            carry <= ci;
            idx   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= chunk_cout;
            if (last_chunk) begin
                sum <= acc_next;
                co  <= chunk_cout;
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef SIGNED_OVF_EN
    // The top chunk holds the word's MSB, so its carry-in/carry-out pair
    // gives the two's-complement overflow of the whole addition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state == RUN) && last_chunk) begin
            ovf <= chunk_cmsb ^ chunk_cout;
        end
    end
`else
    logic unused_cmsb;
    assign unused_cmsb = chunk_cmsb;
`endif

endmodule
